// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with valid/ready load and gapless framing
// Optional even-parity bit appended after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

`ifdef PISO_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [FLEN-1:0] sreg;
  logic [CW-1:0]   cnt;
  logic [FLEN-1:0] frame;
  logic            take;

  // The frame is laid out in transmit order so the top bit of sreg is always the bit on the wire.
  always_comb begin
    frame = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST)
        frame[FLEN-WIDTH+i] = load_data[i];
      else
        frame[FLEN-1-i] = load_data[i];
    end
`ifdef PISO_TX_PARITY_EN
    frame[0] = ^load_data;
`endif
  end

  // sout_last is a register that is high exactly in the final SHIFT cycle, so ready needs no compare.
  assign load_ready = rst && ((state == IDLE) || sout_last);
  assign take       = load_valid && load_ready;
  assign sout       = sreg[FLEN-1];
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end else if (take) begin
      state      <= SHIFT;
      sreg       <= frame;
      cnt        <= CW'(FLEN - 1);
      sout_valid <= 1'b1;
      sout_last  <= 1'b0;
    end else if (state == SHIFT && cnt != '0) begin
      sreg       <= {sreg[FLEN-2:0], 1'b0};
      cnt        <= cnt - 1'b1;
      sout_last  <= (cnt == CW'(1));
    end else begin
      // Clearing sreg on the way back to IDLE keeps sout at 0 between frames.
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end
  end

endmodule
